serial_subtractor_ctrl: RTL and testbench

Bit-serial multi-bit subtractor controller. It sequences a single 1-bit full-subtractor cell, built from 2:1 muxes, across WIDTH bits, LSB first, to compute a − b. It has a start/busy/done handshake and latches the difference and final borrow. It sits between a requester, such as a test/control FSM, and the shared mux-based subtractor datapath.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor_mux2x1.sv | 23 ++
 rtl/mux2x1.sv | 11 +
 rtl/serial_subtractor_ctrl.sv | 99 +++++++++
 tb/tb_serial_subtractor_ctrl.sv | 127 ++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor controller.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor_mux2x1.sv
// Combinational 1-bit full subtractor built only from 2:1 muxes.
// p = x^y selects between propagating the incoming borrow (p=0) and
// generating/killing it from y (p=1, where x!=y so ~x&y reduces to y).
module full_subtractor_mux2x1 (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic p;
   logic y_n;
   logic bin_n;

   assign y_n   = ~y;
   assign bin_n = ~bin;

   mux2x1 u_xor_xy (.sel(x), .in0(y),   .in1(y_n),   .y(p));
   mux2x1 u_xor_d  (.sel(p), .in0(bin), .in1(bin_n), .y(d));
   mux2x1 u_borrow (.sel(p), .in0(bin), .in1(y),     .y(bout));

endmodule

// File: rtl/mux2x1.sv
// 2:1 multiplexer primitive used to build the subtractor cell.
module mux2x1 (
   input  logic sel,
   input  logic in0,
   input  logic in1,
   output logic y
);

   assign y = sel ? in1 : in0;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a-b controller: walks one full-subtractor cell over WIDTH bits,
// LSB first, with a start/busy/done handshake.
// Optional build macro SERIAL_SUB_SAT_EN: clamp diff to 0 on underflow.
module serial_subtractor_ctrl
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state, next_state;
   logic [WIDTH-1:0]   a_sh, b_sh, res, res_nxt;
   logic               brw;
   logic [CNT_W-1:0]   cnt;
   logic               d, bout, last;

   full_subtractor_mux2x1 u_cell (
      .x   (a_sh[0]),
      .y   (b_sh[0]),
      .bin (brw),
      .d   (d),
      .bout(bout)
   );

   assign last    = (cnt == CNT_W'(WIDTH - 1));
   assign res_nxt = {d, res[WIDTH-1:1]};
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic: start only matters in IDLE, DONE lasts one cycle
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = SHIFT;
         SHIFT:   if (last)  next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Operand capture, serial shifting and result latching on the last bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh       <= '0;
         b_sh       <= '0;
         res        <= '0;
         brw        <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh <= a;
                  b_sh <= b;
                  brw  <= 1'b0;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               res  <= res_nxt;
               brw  <= bout;
               if (last) begin
`ifdef SERIAL_SUB_SAT_EN
                  diff <= bout ? '0 : res_nxt;
`else
                  diff <= res_nxt;
`endif
                  borrow_out <= bout;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed self-checking bench for serial_subtractor_ctrl (WIDTH=8).
module tb_serial_subtractor_ctrl;

   localparam int W = 8;
`ifdef SERIAL_SUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         busy, done, borrow_out;
   logic [W-1:0] diff;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   serial_subtractor_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issue one op at a negedge; poke_at>=0 pulses a competing start mid-op.
   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb, input int poke_at);
      a = av; b = bv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_nodone"}, done, 0);
         if (i == poke_at) begin a = 8'd1; b = 8'd2; start = 1'b1; end
         if (i == poke_at + 1) start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy_in_done"}, busy, 1);
      chk({tag, "_diff"}, diff, ed);
      chk({tag, "_borrow"}, borrow_out, eb);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk({tag, "_idle_after"}, busy, 0);
         chk({tag, "_done_low"}, done, 0);
         chk({tag, "_diff_hold"}, diff, ed);
      end
   endtask

   initial begin
      int ndone, c1, c2;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow_out, 0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      run_op("basic", 8'd100, 8'd37, 8'd63, 1'b0, -1);
      run_op("under", 8'd5, 8'd9, SAT ? 8'd0 : 8'd252, 1'b1, -1);
      run_op("zero", 8'd0, 8'd0, 8'd0, 1'b0, -1);
      run_op("max", 8'd255, 8'd255, 8'd0, 1'b0, -1);
      run_op("zm1", 8'd0, 8'd1, SAT ? 8'd0 : 8'd255, 1'b1, -1);
      run_op("busy_start", 8'd200, 8'd50, 8'd150, 1'b0, 2);

      // Asynchronous reset in the middle of an operation
      a = 8'd77; b = 8'd7; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_diff", diff, 0);
      chk("midrst_borrow", borrow_out, 0);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < W + 3; i++) begin
         @(negedge clk);
         chk("midrst_no_done", done, 0);
      end
      run_op("after_rst", 8'd77, 8'd7, 8'd70, 1'b0, -1);

      // Back-to-back with start held high
      a = 8'd10; b = 8'd3; start = 1'b1;
      ndone = 0; c1 = 0; c2 = 0;
      for (int i = 0; i < 40 && ndone < 2; i++) begin
         @(negedge clk);
         if (i == 1) begin a = 8'd3; b = 8'd10; end
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               c1 = cyc;
               chk("b2b_diff1", diff, 8'd7);
               chk("b2b_borrow1", borrow_out, 0);
            end else begin
               c2 = cyc;
               start = 1'b0;
               chk("b2b_diff2", diff, SAT ? 8'd0 : 8'd249);
               chk("b2b_borrow2", borrow_out, 1);
            end
         end
      end
      start = 1'b0;
      chk("b2b_two_dones", ndone, 2);
      chk("b2b_interval", c2 - c1, W + 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
